// File: rtl/reg_read_port_arbiter.sv
// reg_read_port_arbiter: shares NUM_PORTS register-file read ports among the
// integer issue lanes at the IS->RR boundary. Lanes are scanned round-robin
// from ptr and granted all-or-nothing; the first denial blocks every later
// lane in the scan and becomes the next head. Identical source registers
// within a cycle share one port. Port addresses and selects register into RR.
module reg_read_port_arbiter #(
    parameter int NUM_LANES  = 4,
    parameter int NUM_PORTS  = 4,
    parameter int PREG_WIDTH = 7,
    parameter int SEL_WIDTH  = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            stall,
    input  logic                            flush,
    input  logic [NUM_LANES-1:0]            req_valid,
    input  logic [NUM_LANES-1:0]            need_a,
    input  logic [NUM_LANES-1:0]            need_b,
    input  logic [NUM_LANES*PREG_WIDTH-1:0] src_a,
    input  logic [NUM_LANES*PREG_WIDTH-1:0] src_b,
    output logic [NUM_LANES-1:0]            grant,
    output logic [NUM_PORTS-1:0]            rd_en,
    output logic [NUM_PORTS*PREG_WIDTH-1:0] rd_addr,
    output logic [NUM_LANES*SEL_WIDTH-1:0]  sel_a,
    output logic [NUM_LANES*SEL_WIDTH-1:0]  sel_b,
    output logic [NUM_LANES-1:0]            sel_vld_a,
    output logic [NUM_LANES-1:0]            sel_vld_b
);

    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic [PTR_W-1:0]                ptr;
    logic [PTR_W-1:0]                nxt_ptr;
    logic                            any_den;
    logic [NUM_LANES-1:0]            gnt_c;
    logic [NUM_PORTS-1:0]            en_c;
    logic [NUM_PORTS*PREG_WIDTH-1:0] addr_c;
    logic [NUM_LANES*SEL_WIDTH-1:0]  sa_c;
    logic [NUM_LANES*SEL_WIDTH-1:0]  sb_c;

    // Round-robin scan. Ports fill from index 0 upward and are never freed
    // within a cycle, so the lowest free port is always the count in use.
    always_comb begin : arb
        int used;
        int l;
        int pa;
        int pb;
        int dem;
        logic [PREG_WIDTH-1:0] ra;
        logic [PREG_WIDTH-1:0] rb;
        logic merge;
        gnt_c   = '0;
        en_c    = '0;
        addr_c  = '0;
        sa_c    = '0;
        sb_c    = '0;
        nxt_ptr = ptr;
        any_den = 1'b0;
        used    = 0;
        for (int k = 0; k < NUM_LANES; k++) begin
            l = int'(ptr) + k;
            if (l >= NUM_LANES) l = l - NUM_LANES;
            ra    = src_a[l*PREG_WIDTH +: PREG_WIDTH];
            rb    = src_b[l*PREG_WIDTH +: PREG_WIDTH];
            merge = need_a[l] && (ra == rb);
            pa    = -1;
            pb    = -1;
            dem   = 0;
            if (req_valid[l] && !any_den) begin
                // Look for operands already mapped by an earlier lane.
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (p < used && pa < 0 && addr_c[p*PREG_WIDTH +: PREG_WIDTH] == ra) pa = p;
                    if (p < used && pb < 0 && addr_c[p*PREG_WIDTH +: PREG_WIDTH] == rb) pb = p;
                end
                if (need_a[l] && pa < 0) dem = dem + 1;
                if (need_b[l] && pb < 0 && !merge) dem = dem + 1;
                if (used + dem <= NUM_PORTS) begin
                    gnt_c[l] = 1'b1;
                    if (need_a[l]) begin
                        if (pa < 0) begin
                            pa = used;
                            en_c[used] = 1'b1;
                            addr_c[used*PREG_WIDTH +: PREG_WIDTH] = ra;
                            used = used + 1;
                        end
                        sa_c[l*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(pa);
                    end
                    if (need_b[l]) begin
                        if (pb < 0) begin
                            if (merge) begin
                                pb = pa;
                            end else begin
                                pb = used;
                                en_c[used] = 1'b1;
                                addr_c[used*PREG_WIDTH +: PREG_WIDTH] = rb;
                                used = used + 1;
                            end
                        end
                        sb_c[l*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(pb);
                    end
                end else begin
                    any_den = 1'b1;
                    nxt_ptr = PTR_W'(l);
                end
            end
        end
    end

    // Stall suppresses every grant so no lane leaves IS.
    always_comb grant = stall ? '0 : gnt_c;

    // Head of the scan moves to the first denied lane; held on stall/flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (!stall && !flush && any_den) begin
            ptr <= nxt_ptr;
        end
    end

    // RR stage registers: flush clears (beats stall), stall holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en     <= '0;
            rd_addr   <= '0;
            sel_a     <= '0;
            sel_b     <= '0;
            sel_vld_a <= '0;
            sel_vld_b <= '0;
        end else if (flush) begin
            rd_en     <= '0;
            rd_addr   <= '0;
            sel_a     <= '0;
            sel_b     <= '0;
            sel_vld_a <= '0;
            sel_vld_b <= '0;
        end else if (!stall) begin
            rd_en     <= en_c;
            rd_addr   <= addr_c;
            sel_a     <= sa_c;
            sel_b     <= sb_c;
            sel_vld_a <= gnt_c & need_a;
            sel_vld_b <= gnt_c & need_b;
        end
    end

endmodule

// File: tb/tb_reg_read_port_arbiter.sv
// Bench for reg_read_port_arbiter: a set-based reference model predicts the
// grant each cycle and pushes the expected RR state to a queue; the queue is
// popped one edge later and compared against the registered outputs.
module tb_reg_read_port_arbiter;

    localparam int NL = 4;
    localparam int NP = 4;
    localparam int PW = 7;
    localparam int SW = 2;

    typedef struct packed {
        logic [NP-1:0]    en;
        logic [NP*PW-1:0] addr;
        logic [NL*SW-1:0] sa;
        logic [NL*SW-1:0] sb;
        logic [NL-1:0]    va;
        logic [NL-1:0]    vb;
    } rr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0;
    logic flush = 1'b0;
    logic [NL-1:0]    reqv = '0;
    logic [NL-1:0]    na = '0;
    logic [NL-1:0]    nb = '0;
    logic [NL*PW-1:0] sa_in = '0;
    logic [NL*PW-1:0] sb_in = '0;
    logic [NL-1:0]    grant;
    logic [NP-1:0]    rd_en;
    logic [NP*PW-1:0] rd_addr;
    logic [NL*SW-1:0] sel_a;
    logic [NL*SW-1:0] sel_b;
    logic [NL-1:0]    sel_vld_a;
    logic [NL-1:0]    sel_vld_b;
    rr_t              rr_obs;

    int tests = 0;
    int fails = 0;

    int    m_ptr = 0;
    rr_t   m_rr = '0;
    rr_t   exp_rr;
    rr_t   snap;
    logic [NL-1:0] exp_grant;
    rr_t   exp_q[$];

    reg_read_port_arbiter #(.NUM_LANES(NL), .NUM_PORTS(NP), .PREG_WIDTH(PW), .SEL_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .req_valid(reqv), .need_a(na), .need_b(nb), .src_a(sa_in), .src_b(sb_in),
        .grant(grant), .rd_en(rd_en), .rd_addr(rd_addr),
        .sel_a(sel_a), .sel_b(sel_b), .sel_vld_a(sel_vld_a), .sel_vld_b(sel_vld_b)
    );

    assign rr_obs = {rd_en, rd_addr, sel_a, sel_b, sel_vld_a, sel_vld_b};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int find_in(input int q[$], input int v);
        foreach (q[i]) if (q[i] == v) return i;
        return -1;
    endfunction

    task automatic set_lane(input int l, input logic v, input logic a, input logic b,
                            input int ra, input int rb);
        reqv[l] = v;
        na[l]   = a;
        nb[l]   = b;
        sa_in[l*PW +: PW] = PW'(ra);
        sb_in[l*PW +: PW] = PW'(rb);
    endtask

    task automatic all_two_regs();
        for (int l = 0; l < NL; l++) set_lane(l, 1'b1, 1'b1, 1'b1, 2*l+1, 2*l+2);
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_rr  = '0;
        exp_q.delete();
    endtask

    // Reference: allocation is a list of distinct register numbers; a port
    // index is the position of the register in that list.
    task automatic model_step();
        int alloc[$];
        int fresh[$];
        int fd;
        logic blocked;
        logic [NL-1:0] g;
        rr_t nx;
        nx = '0; g = '0; blocked = 1'b0; fd = -1;
        alloc.delete();
        for (int k = 0; k < NL; k++) begin
            int l, ra, rb;
            l  = (m_ptr + k) % NL;
            ra = int'(sa_in[l*PW +: PW]);
            rb = int'(sb_in[l*PW +: PW]);
            fresh.delete();
            if (reqv[l] && !blocked) begin
                if (na[l] && find_in(alloc, ra) < 0) fresh.push_back(ra);
                if (nb[l] && find_in(alloc, rb) < 0 && find_in(fresh, rb) < 0) fresh.push_back(rb);
                if (alloc.size() + fresh.size() > NP) begin
                    blocked = 1'b1;
                    fd = l;
                end else begin
                    g[l] = 1'b1;
                    foreach (fresh[i]) alloc.push_back(fresh[i]);
                    if (na[l]) begin nx.va[l] = 1'b1; nx.sa[l*SW +: SW] = SW'(find_in(alloc, ra)); end
                    if (nb[l]) begin nx.vb[l] = 1'b1; nx.sb[l*SW +: SW] = SW'(find_in(alloc, rb)); end
                end
            end
        end
        foreach (alloc[p]) begin
            nx.en[p] = 1'b1;
            nx.addr[p*PW +: PW] = PW'(alloc[p]);
        end
        exp_grant = stall ? '0 : g;
        if (flush) m_rr = '0;
        else if (!stall) m_rr = nx;
        if (!stall && !flush && fd >= 0) m_ptr = fd;
        exp_q.push_back(m_rr);
    endtask

    // Inputs are settled by the falling edge; predict there.
    task automatic pre();
        @(negedge clk);
        model_step();
    endtask

    // Advance past the active edge and fetch the prediction for this edge.
    task automatic post();
        @(posedge clk);
        #1;
        exp_rr = exp_q.pop_front();
    endtask

    task automatic test_reset();
        reqv = '0; na = '0; nb = '0; stall = 1'b1; flush = 1'b0;
        #1 rst = 1'b0;
        #12;
        model_reset();
        tests++; if (rr_obs !== '0) begin fails++; $display("FAIL reset_rr: got %h want 0", rr_obs); end
        tests++; if (grant !== '0) begin fails++; $display("FAIL reset_grant: got %b want 0000", grant); end
        @(negedge clk);
        rst = 1'b1; stall = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        all_two_regs();
        pre();
        tests++; if (grant !== exp_grant || grant !== 4'b0011) begin fails++; $display("FAIL rr_grant0: got %b want 0011 (model %b)", grant, exp_grant); end
        post();
        tests++; if (rr_obs !== exp_rr) begin fails++; $display("FAIL rr_out0: got %h want %h", rr_obs, exp_rr); end
        tests++; if (rd_addr !== {7'd4, 7'd3, 7'd2, 7'd1} || rd_en !== 4'b1111) begin fails++; $display("FAIL rr_addr0: got %h en %b want 04030201-packed en 1111", rd_addr, rd_en); end
        pre();
        tests++; if (grant !== exp_grant || grant !== 4'b1100) begin fails++; $display("FAIL rr_grant1: got %b want 1100", grant); end
        post();
        tests++; if (rr_obs !== exp_rr) begin fails++; $display("FAIL rr_out1: got %h want %h", rr_obs, exp_rr); end
    endtask

    task automatic test_dedup();
        for (int l = 0; l < NL; l++) set_lane(l, 1'b1, 1'b1, 1'b0, 5, 0);
        set_lane(0, 1'b1, 1'b1, 1'b1, 5, 9);
        pre();
        tests++; if (grant !== exp_grant || grant !== 4'b1111) begin fails++; $display("FAIL dedup_grant: got %b want 1111", grant); end
        post();
        tests++; if (rr_obs !== exp_rr) begin fails++; $display("FAIL dedup_out: got %h want %h", rr_obs, exp_rr); end
        tests++;
        if (rd_en !== 4'b0011 || rd_addr[6:0] !== 7'd5 || rd_addr[13:7] !== 7'd9 ||
            sel_a !== '0 || sel_b[1:0] !== 2'd1) begin
            fails++; $display("FAIL dedup_fields: en %b addr %h sel_a %h sel_b %h", rd_en, rd_addr, sel_a, sel_b);
        end
    endtask

    task automatic test_bypass();
        for (int l = 0; l < NL; l++) set_lane(l, 1'b1, 1'b0, 1'b0, l, l);
        pre();
        tests++; if (grant !== exp_grant || grant !== 4'b1111) begin fails++; $display("FAIL bypass_grant: got %b want 1111", grant); end
        post();
        tests++; if (rd_en !== '0 || sel_vld_a !== '0 || sel_vld_b !== '0 || rr_obs !== exp_rr) begin
            fails++; $display("FAIL bypass_out: got %h want %h", rr_obs, exp_rr);
        end
    endtask

    task automatic test_wrap();
        set_lane(0, 1'b1, 1'b1, 1'b1, 1, 2);
        set_lane(1, 1'b1, 1'b1, 1'b1, 3, 4);
        set_lane(2, 1'b1, 1'b0, 1'b0, 0, 0);
        set_lane(3, 1'b1, 1'b1, 1'b0, 7, 0);
        pre();
        tests++; if (grant !== exp_grant || grant !== 4'b0111) begin fails++; $display("FAIL wrap_setup: got %b want 0111", grant); end
        post();
        set_lane(3, 1'b1, 1'b1, 1'b1, 11, 12);
        set_lane(0, 1'b1, 1'b1, 1'b1, 13, 14);
        set_lane(1, 1'b1, 1'b1, 1'b0, 15, 0);
        set_lane(2, 1'b0, 1'b0, 1'b0, 0, 0);
        pre();
        tests++; if (grant !== exp_grant || grant !== 4'b1001) begin fails++; $display("FAIL wrap_grant: got %b want 1001", grant); end
        post();
        tests++; if (rr_obs !== exp_rr) begin fails++; $display("FAIL wrap_out: got %h want %h", rr_obs, exp_rr); end
        all_two_regs();
        pre();
        tests++; if (grant !== exp_grant || grant !== 4'b0110) begin fails++; $display("FAIL wrap_head: got %b want 0110", grant); end
        post();
    endtask

    task automatic test_stall_flush();
        all_two_regs();
        pre();
        tests++; if (grant !== 4'b1001) begin fails++; $display("FAIL stall_pre: got %b want 1001", grant); end
        post();
        snap = rr_obs;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            pre();
            tests++; if (grant !== '0) begin fails++; $display("FAIL stall_grant: got %b want 0000", grant); end
            post();
            tests++; if (rr_obs !== snap || rr_obs !== exp_rr) begin fails++; $display("FAIL stall_hold: got %h want %h", rr_obs, snap); end
        end
        stall = 1'b0;
        pre();
        tests++; if (grant !== exp_grant || grant !== 4'b0110) begin fails++; $display("FAIL stall_resume: got %b want 0110", grant); end
        post();
        stall = 1'b1; flush = 1'b1;
        pre();
        tests++; if (grant !== '0) begin fails++; $display("FAIL sf_grant: got %b want 0000", grant); end
        post();
        tests++; if (rd_en !== '0 || sel_vld_a !== '0 || sel_vld_b !== '0 || rr_obs !== exp_rr) begin
            fails++; $display("FAIL sf_clear: got %h want %h", rr_obs, exp_rr);
        end
        stall = 1'b0;
        pre();
        tests++; if (grant !== exp_grant || grant !== 4'b1001) begin fails++; $display("FAIL flush_grant: got %b want 1001", grant); end
        post();
        tests++; if (rr_obs !== '0) begin fails++; $display("FAIL flush_clear: got %h want 0", rr_obs); end
        flush = 1'b0;
        pre();
        tests++; if (grant !== exp_grant || grant !== 4'b1001) begin fails++; $display("FAIL flush_ptr_hold: got %b want 1001", grant); end
        post();
        tests++; if (rr_obs !== exp_rr) begin fails++; $display("FAIL flush_after: got %h want %h", rr_obs, exp_rr); end
    endtask

    task automatic test_async_reset();
        all_two_regs();
        pre();
        post();
        tests++; if (rd_en !== 4'b1111) begin fails++; $display("FAIL ar_setup: got %b want 1111", rd_en); end
        #2 rst = 1'b0;
        #1;
        model_reset();
        tests++; if (rr_obs !== '0) begin fails++; $display("FAIL ar_clear: got %h want 0", rr_obs); end
        @(posedge clk); #1;
        rst = 1'b1;
        pre();
        tests++; if (grant !== exp_grant || grant !== 4'b0011) begin fails++; $display("FAIL ar_restart: got %b want 0011", grant); end
        post();
        tests++; if (rr_obs !== exp_rr) begin fails++; $display("FAIL ar_out: got %h want %h", rr_obs, exp_rr); end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 60; c++) begin
            for (int l = 0; l < NL; l++)
                set_lane(l, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            pre();
            tests++; if (grant !== exp_grant) begin fails++; $display("FAIL b2b_grant[%0d]: got %b want %b", c, grant, exp_grant); end
            post();
            tests++; if (rr_obs !== exp_rr) begin fails++; $display("FAIL b2b_out[%0d]: got %h want %h", c, rr_obs, exp_rr); end
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_dedup();
        test_bypass();
        test_wrap();
        test_stall_flush();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
